// File: rtl/better_neighbor_writer.sv
// Scans the neighbor Q-table, appends IDs that beat _mybest to the betterNeighbor list,
// then writes the list length. Optional macro SELF_FILTER_EN excludes MY_NODE_ID entries.
module better_neighbor_writer #(
    parameter logic [15:0] NB_BASE       = 16'h0600,
    parameter logic [15:0] BN_BASE       = 16'h0668,
    parameter logic [15:0] BN_COUNT_ADDR = 16'h068C,
    parameter logic [15:0] MAX_BN        = 16'd18
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start_betterNeighbor,
    input  logic [15:0] _mybest,
    input  logic [15:0] MY_NODE_ID,
    input  logic [15:0] neighborCount,
    input  logic [15:0] data_in,
    output logic [15:0] address,
    output logic [15:0] data_out,
    output logic        wr_en,
    output logic [15:0] betterNeighborCount,
    output logic [15:0] _bestvalue,
    output logic [15:0] _bestneighborID,
    output logic        overflow,
    output logic        done_betterNeighbor,
    output logic [7:0]  cstate
);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StGetId,
        StGetQ,
        StEval,
        StWrite,
        StWrcnt,
        StFin,
        StDone
    } state_e;

    localparam logic [15:0] NoNeighbor = 16'd100;

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] i_q, i_d;
    logic [15:0] count_q, count_d;
    logic [15:0] id_q, id_d;
    logic [15:0] q_q, q_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        wr_q, wr_d;
    logic [15:0] best_q, best_d;
    logic [15:0] best_id_q, best_id_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic        is_self;
    logic        qualify;
    logic        beats_best;
    logic        has_room;

`ifdef SELF_FILTER_EN
    assign is_self = (id_q == MY_NODE_ID);
`else
    logic unused_my_node_id;
    assign unused_my_node_id = ^MY_NODE_ID;
    assign is_self           = 1'b0;
`endif

    // Both compares are strict: ties neither qualify nor displace the earlier best.
    assign qualify    = !is_self && (q_q > _mybest);
    assign beats_best = !is_self && (q_q > best_q);
    assign has_room   = (count_q < MAX_BN);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q   <= StIdle;
            n_q       <= '0;
            i_q       <= '0;
            count_q   <= '0;
            id_q      <= '0;
            q_q       <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            best_q    <= '0;
            best_id_q <= NoNeighbor;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            i_q       <= i_d;
            count_q   <= count_d;
            id_q      <= id_d;
            q_q       <= q_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            wr_q      <= wr_d;
            best_q    <= best_d;
            best_id_q <= best_id_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_betterNeighbor) state_d = StAddr;
            StAddr:  state_d = (i_q == n_q) ? StWrcnt : StGetId;
            StGetId: state_d = StGetQ;
            StGetQ:  state_d = StEval;
            StEval:  state_d = (qualify && has_room) ? StWrite : StAddr;
            StWrite: state_d = StAddr;
            StWrcnt: state_d = StFin;
            StFin:   state_d = StDone;
            StDone:  if (!start_betterNeighbor) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        n_d       = n_q;
        i_d       = i_q;
        count_d   = count_q;
        id_d      = id_q;
        q_d       = q_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        wr_d      = wr_q;
        best_d    = best_q;
        best_id_d = best_id_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        unique case (state_q)
            StIdle: begin
                if (start_betterNeighbor) begin
                    n_d       = neighborCount;
                    i_d       = '0;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    best_d    = '0;
                    best_id_d = NoNeighbor;
                    done_d    = 1'b0;
                end
            end
            StAddr: begin
                if (i_q != n_q) addr_d = NB_BASE + (i_q << 2);
            end
            StGetId: begin
                id_d   = data_in;
                addr_d = addr_q + 16'd2;
            end
            StGetQ: begin
                q_d = data_in;
            end
            StEval: begin
                if (beats_best) begin
                    best_d    = q_q;
                    best_id_d = id_q;
                end
                if (qualify && has_room) begin
                    addr_d = BN_BASE + (count_q << 1);
                    dout_d = id_q;
                    wr_d   = 1'b1;
                end else begin
                    if (qualify) ovf_d = 1'b1;
                    i_d = i_q + 16'd1;
                end
            end
            StWrite: begin
                wr_d    = 1'b0;
                count_d = count_q + 16'd1;
                i_d     = i_q + 16'd1;
            end
            StWrcnt: begin
                addr_d = BN_COUNT_ADDR;
                dout_d = count_q;
                wr_d   = 1'b1;
            end
            StFin: begin
                wr_d   = 1'b0;
                done_d = 1'b1;
            end
            StDone: begin
                if (!start_betterNeighbor) done_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign address             = addr_q;
    assign data_out            = dout_q;
    assign wr_en               = wr_q;
    assign betterNeighborCount = count_q;
    assign _bestvalue          = best_q;
    assign _bestneighborID     = best_id_q;
    assign overflow            = ovf_q;
    assign done_betterNeighbor = done_q;
    assign cstate              = {4'b0000, state_q};

endmodule

// File: tb/tb_better_neighbor_writer.sv
// Directed bench for better_neighbor_writer: memory model, list/best reference model,
// per-cycle write monitor and hand-computed pins. Honours SELF_FILTER_EN like the RTL.
module tb_better_neighbor_writer;

    logic        clock;
    logic        nreset;
    logic        start_betterNeighbor;
    logic [15:0] _mybest;
    logic [15:0] MY_NODE_ID;
    logic [15:0] neighborCount;
    logic [15:0] data_in;
    logic [15:0] address;
    logic [15:0] data_out;
    logic        wr_en;
    logic [15:0] betterNeighborCount;
    logic [15:0] _bestvalue;
    logic [15:0] _bestneighborID;
    logic        overflow;
    logic        done_betterNeighbor;
    logic [7:0]  cstate;

    better_neighbor_writer dut (
        .clock               (clock),
        .nreset              (nreset),
        .start_betterNeighbor(start_betterNeighbor),
        ._mybest             (_mybest),
        .MY_NODE_ID          (MY_NODE_ID),
        .neighborCount       (neighborCount),
        .data_in             (data_in),
        .address             (address),
        .data_out            (data_out),
        .wr_en               (wr_en),
        .betterNeighborCount (betterNeighborCount),
        ._bestvalue          (_bestvalue),
        ._bestneighborID     (_bestneighborID),
        .overflow            (overflow),
        .done_betterNeighbor (done_betterNeighbor),
        .cstate              (cstate)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] mem [0:4095];
    assign data_in = mem[address[11:0]];
    always @(posedge clock) if (wr_en) mem[address[11:0]] <= data_out;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Stimulus table and reference model results.
    logic [15:0] tb_id [0:31];
    logic [15:0] tb_q  [0:31];
    logic [15:0] exp_wa [$];
    logic [15:0] exp_wd [$];
    int          exp_cnt;
    logic        exp_ovf;
    logic [15:0] exp_best;
    logic [15:0] exp_bid;
    int          exp_lat;

    // Write monitor: every strobe must match the next expected (address, data) pair.
    logic prev_wr = 1'b0;
    always @(negedge clock) begin
        if (nreset && wr_en) begin
            check("wr_en single cycle", {31'd0, prev_wr}, 32'd0);
            if (exp_wa.size() == 0) begin
                check("unexpected write", {16'd0, address}, 32'hFFFF_FFFF);
            end else begin
                check("write address", {16'd0, address}, {16'd0, exp_wa.pop_front()});
                check("write data", {16'd0, data_out}, {16'd0, exp_wd.pop_front()});
            end
        end
        prev_wr = nreset && wr_en;
    end

    task automatic build_model(input int n, input logic [15:0] mybest, input logic [15:0] myid);
        logic skip;
        exp_wa.delete();
        exp_wd.delete();
        exp_cnt  = 0;
        exp_ovf  = 1'b0;
        exp_best = 16'd0;
        exp_bid  = 16'd100;
        for (int k = 0; k < n; k++) begin
`ifdef SELF_FILTER_EN
            skip = (tb_id[k] == myid);
`else
            skip = 1'b0;
            if (myid == 16'hFFFF) skip = 1'b0;
`endif
            if (!skip) begin
                if (tb_q[k] > exp_best) begin
                    exp_best = tb_q[k];
                    exp_bid  = tb_id[k];
                end
                if (tb_q[k] > mybest) begin
                    if (exp_cnt < 18) begin
                        exp_wa.push_back(16'(16'h0668 + 2 * exp_cnt));
                        exp_wd.push_back(tb_id[k]);
                        exp_cnt++;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
        end
        exp_wa.push_back(16'h068C);
        exp_wd.push_back(16'(exp_cnt));
        exp_lat = 4 * n + exp_cnt + 4;
    endtask

    task automatic run_test(input string name, input int n, input logic [15:0] mybest,
                            input logic [15:0] myid);
        int edges;
        for (int k = 0; k < n; k++) begin
            mem[12'h600 + 12'(4 * k)] = tb_id[k];
            mem[12'h602 + 12'(4 * k)] = tb_q[k];
        end
        build_model(n, mybest, myid);
        @(negedge clock);
        _mybest              = mybest;
        MY_NODE_ID           = myid;
        neighborCount        = 16'(n);
        start_betterNeighbor = 1'b1;
        edges = 0;
        do begin
            @(posedge clock);
            edges++;
            #1;
        end while (!done_betterNeighbor && edges < 2000);
        check({name, " done latency"}, edges, exp_lat);
        check({name, " count"}, {16'd0, betterNeighborCount}, exp_cnt);
        check({name, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check({name, " bestvalue"}, {16'd0, _bestvalue}, {16'd0, exp_best});
        check({name, " bestID"}, {16'd0, _bestneighborID}, {16'd0, exp_bid});
        check({name, " count word"}, {16'd0, mem[12'h68C]}, exp_cnt);
        check({name, " writes drained"}, exp_wa.size(), 0);
        @(negedge clock);
        check({name, " done held"}, {31'd0, done_betterNeighbor}, 32'd1);
        start_betterNeighbor = 1'b0;
        @(posedge clock);
        #1;
        check({name, " done cleared"}, {31'd0, done_betterNeighbor}, 32'd0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, " address"}, {16'd0, address}, 32'd0);
        check({name, " data_out"}, {16'd0, data_out}, 32'd0);
        check({name, " wr_en"}, {31'd0, wr_en}, 32'd0);
        check({name, " count"}, {16'd0, betterNeighborCount}, 32'd0);
        check({name, " bestvalue"}, {16'd0, _bestvalue}, 32'd0);
        check({name, " bestID"}, {16'd0, _bestneighborID}, 32'd100);
        check({name, " overflow"}, {31'd0, overflow}, 32'd0);
        check({name, " done"}, {31'd0, done_betterNeighbor}, 32'd0);
        check({name, " cstate"}, {24'd0, cstate}, 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'd0;
        nreset               = 1'b1;
        start_betterNeighbor = 1'b0;
        _mybest              = 16'd0;
        MY_NODE_ID           = 16'd0;
        neighborCount        = 16'd0;
        #2 nreset = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(negedge clock);
        nreset = 1'b1;

        // T1
        tb_id[0] = 16'd5; tb_q[0] = 16'h0080;
        tb_id[1] = 16'd7; tb_q[1] = 16'h0200;
        tb_id[2] = 16'd9; tb_q[2] = 16'h0150;
        run_test("T1", 3, 16'h0100, 16'd1);
        check("T1 pin latency", exp_lat, 18);
        check("T1 pin list0", {16'd0, mem[12'h668]}, 32'd7);
        check("T1 pin list1", {16'd0, mem[12'h66A]}, 32'd9);
        check("T1 pin count", {16'd0, mem[12'h68C]}, 32'd2);
        check("T1 pin best", {_bestvalue, _bestneighborID}, {16'h0200, 16'd7});

        // T2
        run_test("T2", 0, 16'h0100, 16'd1);
        check("T2 pin latency", exp_lat, 4);
        check("T2 pin bestID", {16'd0, _bestneighborID}, 32'd100);

        // T3: list overflow
        for (int k = 0; k < 20; k++) begin
            tb_id[k] = 16'(10 + k);
            tb_q[k]  = 16'h0FFF;
        end
        run_test("T3", 20, 16'h0000, 16'd1);
        check("T3 pin count", {16'd0, mem[12'h68C]}, 32'd18);
        check("T3 pin overflow", {31'd0, overflow}, 32'd1);
        check("T3 pin last", {16'd0, mem[12'h68A]}, 32'd27);

        // T4: ties with _mybest never qualify
        for (int k = 0; k < 4; k++) begin
            tb_id[k] = 16'(20 + k);
            tb_q[k]  = 16'h0100;
        end
        run_test("T4", 4, 16'h0100, 16'd1);
        check("T4 pin count", {16'd0, betterNeighborCount}, 32'd0);
        check("T4 pin best", {_bestvalue, _bestneighborID}, {16'h0100, 16'd20});

        // T5: own ID holds the highest Q
        tb_id[0] = 16'd1; tb_q[0] = 16'h0100;
        tb_id[1] = 16'd3; tb_q[1] = 16'h0500;
        tb_id[2] = 16'd2; tb_q[2] = 16'h0200;
        run_test("T5", 3, 16'h0080, 16'd3);
`ifdef SELF_FILTER_EN
        check("T5 pin count", {16'd0, mem[12'h68C]}, 32'd2);
        check("T5 pin best", {_bestvalue, _bestneighborID}, {16'h0200, 16'd2});
`else
        check("T5 pin count", {16'd0, mem[12'h68C]}, 32'd3);
        check("T5 pin best", {_bestvalue, _bestneighborID}, {16'h0500, 16'd3});
`endif

        // T6: abort during EVAL of entry 1, then a clean run
        tb_id[0] = 16'd4; tb_q[0] = 16'h0050;
        tb_id[1] = 16'd6; tb_q[1] = 16'h0300;
        tb_id[2] = 16'd8; tb_q[2] = 16'h0010;
        for (int k = 0; k < 3; k++) begin
            mem[12'h600 + 12'(4 * k)] = tb_id[k];
            mem[12'h602 + 12'(4 * k)] = tb_q[k];
        end
        exp_wa.delete();
        exp_wd.delete();
        @(negedge clock);
        _mybest              = 16'h0100;
        neighborCount        = 16'd3;
        start_betterNeighbor = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("T6 pre-abort best", {16'd0, _bestvalue}, 32'h0050);
        #1;
        nreset               = 1'b0;
        start_betterNeighbor = 1'b0;
        #1 check_reset_state("T6 abort");
        @(negedge clock);
        nreset = 1'b1;
        run_test("T6 rerun", 3, 16'h0100, 16'd1);
        check("T6 pin list0", {16'd0, mem[12'h668]}, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
